// File: rtl/dither_pkg.sv
// Shared constants and state encoding for the frame sequencer.
//
// Contents:
//   IMAGEX, IMAGEY    default image geometry in pixels
//   IMAGE_SIZE        pixels per frame
//   RGB_SIZE          pixel width in bits
//   ADDR_W            frame address width
//   seq_state_t       sequencer state encoding
//   state_is_busy()   true for every state except IDLE
package dither_pkg;

    localparam int IMAGEX     = 64;
    localparam int IMAGEY     = 64;
    localparam int IMAGE_SIZE = IMAGEX * IMAGEY;
    localparam int RGB_SIZE   = 8;
    localparam int ADDR_W     = $clog2(IMAGE_SIZE);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LOAD  = 4'd1,
        ST_RD    = 4'd2,
        ST_LAT   = 4'd3,
        ST_PROC  = 4'd4,
        ST_WB    = 4'd5,
        ST_U_RD  = 4'd6,
        ST_U_LAT = 4'd7,
        ST_U_TX  = 4'd8
    } seq_state_t;

    // The sequencer counts as busy whenever it has left IDLE.
    function automatic logic state_is_busy(input seq_state_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/frame_addr_counter.sv
// Pixel address counter for the frame sequencer.
//
// Ports:
//   clk, rst   clock and asynchronous active-low reset
//   clr        synchronous clear to 0 (wins over inc)
//   inc        advance by one; holds at DEPTH-1 so the count never wraps
//   addr       current address (registered)
//   last       high while addr equals DEPTH-1
module frame_addr_counter #(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] addr_q;

    // Next-address selection: clear wins, increment saturates at the last pixel.
    always_comb begin
        addr_d = addr_q;
        if (clr) begin
            addr_d = {ADDR_W{1'b0}};
        end else if (inc && (addr_q != LAST_ADDR)) begin
            addr_d = addr_q + ADDR_W'(1);
        end else begin
            addr_d = addr_q;
        end
    end

    // Address register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= {ADDR_W{1'b0}};
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;
    assign last = (addr_q == LAST_ADDR);

endmodule

// File: rtl/frame_sequencer.sv
// Frame sequencer: loads a frame of pixels from the SPI receiver into the
// frame RAM, runs every pixel through the pixel algorithm unit in place,
// then streams the processed frame out to the SPI transmitter.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start, abort             frame start pulse (IDLE only), abort level
//   rx_valid/rx_ready/rx_data   inbound pixel handshake
//   tx_valid/tx_ready/tx_data   outbound pixel handshake
//   ram_addr/ram_wr_en/ram_wdata/ram_rdata   frame RAM port (1-cycle read)
//   pau_req/pau_color/pau_done/pau_result    pixel algorithm unit handshake
//   busy                     high outside IDLE
//   frame_done               one-cycle pulse after the last pixel leaves
module frame_sequencer #(
    parameter int  IMAGEX     = dither_pkg::IMAGEX,
    parameter int  IMAGEY     = dither_pkg::IMAGEY,
    parameter int  RGB_SIZE   = dither_pkg::RGB_SIZE,
    localparam int IMAGE_SIZE = IMAGEX * IMAGEY,
    localparam int ADDR_W     = $clog2(IMAGE_SIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic [RGB_SIZE-1:0] rx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [RGB_SIZE-1:0] tx_data,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_wr_en,
    output logic [RGB_SIZE-1:0] ram_wdata,
    input  logic [RGB_SIZE-1:0] ram_rdata,
    output logic                pau_req,
    output logic [RGB_SIZE-1:0] pau_color,
    input  logic                pau_done,
    input  logic [RGB_SIZE-1:0] pau_result,
    output logic                busy,
    output logic                frame_done
);

    import dither_pkg::*;

    seq_state_t          state_d,      state_q;
    logic [RGB_SIZE-1:0] operand_d,    operand_q;
    logic [RGB_SIZE-1:0] result_d,     result_q;
    logic [RGB_SIZE-1:0] tx_d,         tx_q;
    logic                req_seen_d,   req_seen_q;
    logic                frame_done_d, frame_done_q;
    logic                busy_q;
    logic                rx_ready_q;
    logic                pau_req_q;
    logic                tx_valid_q;

    logic                addr_clr_s;
    logic                addr_inc_s;
    logic [ADDR_W-1:0]   addr_s;
    logic                addr_last_s;
    logic                rx_hs_s;

    frame_addr_counter #(
        .DEPTH  (IMAGE_SIZE),
        .ADDR_W (ADDR_W)
    ) u_addr_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (addr_clr_s),
        .inc  (addr_inc_s),
        .addr (addr_s),
        .last (addr_last_s)
    );

    assign rx_hs_s = rx_valid && rx_ready_q;

    // Next-state and datapath-register logic; abort overrides everything.
    always_comb begin
        state_d      = state_q;
        operand_d    = operand_q;
        result_d     = result_q;
        tx_d         = tx_q;
        req_seen_d   = req_seen_q;
        frame_done_d = 1'b0;
        addr_clr_s   = 1'b0;
        addr_inc_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    addr_clr_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (rx_hs_s && addr_last_s) begin
                    addr_clr_s = 1'b1;
                    state_d    = ST_RD;
                end else if (rx_hs_s) begin
                    addr_inc_s = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RD: begin
                state_d = ST_LAT;
            end
            ST_LAT: begin
                operand_d  = ram_rdata;
                req_seen_d = 1'b0;
                state_d    = ST_PROC;
            end
            ST_PROC: begin
                // pau_done is ignored on the first PROC cycle, when the
                // request has only just been raised.
                req_seen_d = 1'b1;
                if (req_seen_q && pau_done) begin
                    result_d = pau_result;
                    state_d  = ST_WB;
                end else begin
                    state_d = ST_PROC;
                end
            end
            ST_WB: begin
                if (addr_last_s) begin
                    addr_clr_s = 1'b1;
                    state_d    = ST_U_RD;
                end else begin
                    addr_inc_s = 1'b1;
                    state_d    = ST_RD;
                end
            end
            ST_U_RD: begin
                state_d = ST_U_LAT;
            end
            ST_U_LAT: begin
                tx_d    = ram_rdata;
                state_d = ST_U_TX;
            end
            ST_U_TX: begin
                if (tx_ready && addr_last_s) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end else if (tx_ready) begin
                    addr_inc_s = 1'b1;
                    state_d    = ST_U_RD;
                end else begin
                    state_d = ST_U_TX;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                addr_clr_s = 1'b1;
            end
        endcase

        if (abort) begin
            state_d      = ST_IDLE;
            addr_clr_s   = 1'b1;
            addr_inc_s   = 1'b0;
            frame_done_d = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State, datapath registers and the state-decoded handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            operand_q    <= {RGB_SIZE{1'b0}};
            result_q     <= {RGB_SIZE{1'b0}};
            tx_q         <= {RGB_SIZE{1'b0}};
            req_seen_q   <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            rx_ready_q   <= 1'b0;
            pau_req_q    <= 1'b0;
            tx_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            operand_q    <= operand_d;
            result_q     <= result_d;
            tx_q         <= tx_d;
            req_seen_q   <= req_seen_d;
            frame_done_q <= frame_done_d;
            busy_q       <= state_is_busy(state_d);
            rx_ready_q   <= (state_d == ST_LOAD);
            pau_req_q    <= (state_d == ST_PROC);
            tx_valid_q   <= (state_d == ST_U_TX);
        end
    end

    // RAM write port: the LOAD write must land in the same cycle as the
    // receive handshake, so the strobe and data are decoded, not registered.
    always_comb begin
        ram_wr_en = 1'b0;
        ram_wdata = {RGB_SIZE{1'b0}};
        if ((state_q == ST_LOAD) && rx_hs_s) begin
            ram_wr_en = 1'b1;
            ram_wdata = rx_data;
        end else if (state_q == ST_WB) begin
            ram_wr_en = 1'b1;
            ram_wdata = result_q;
        end else begin
            ram_wr_en = 1'b0;
            ram_wdata = {RGB_SIZE{1'b0}};
        end
    end

    assign ram_addr   = addr_s;
    assign rx_ready   = rx_ready_q;
    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_q;
    assign pau_req    = pau_req_q;
    assign pau_color  = operand_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort;
    logic        rx_valid, rx_ready;
    logic [7:0]  rx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  tx_data;
    logic [11:0] ram_addr;
    logic        ram_wr_en;
    logic [7:0]  ram_wdata, ram_rdata;
    logic        pau_req, pau_done;
    logic [7:0]  pau_color, pau_result;
    logic        busy, frame_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int prev_wr = 0;
    int done_cnt = 0;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
        int          gap;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] tx_exp_q[$];
    logic [7:0] mem [0:4095];

    always #10 clk = ~clk;

    frame_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .ram_addr   (ram_addr),
        .ram_wr_en  (ram_wr_en),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .pau_req    (pau_req),
        .pau_color  (pau_color),
        .pau_done   (pau_done),
        .pau_result (pau_result),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Frame RAM with 1-cycle read latency.
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Pixel unit: inverts the colour, done one cycle after the request rises.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pau_done   <= 1'b0;
            pau_result <= 8'h00;
        end else begin
            pau_done   <= pau_req && !pau_done;
            pau_result <= pau_color ^ 8'hFF;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Write monitor: every RAM write must match the head of the write queue.
    always @(negedge clk) begin
        if (rst && ram_wr_en) begin
            if (wr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr %0d data %0h, expected no write", ram_addr, ram_wdata);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("wr_addr", 32'(ram_addr), 32'(e.addr));
                check("wr_data", 32'(ram_wdata), 32'(e.data));
                if (e.gap > 0) check("wr_gap", 32'(cyc - prev_wr), 32'(e.gap));
            end
            prev_wr = cyc;
        end
    end

    // Transmit monitor: each accepted byte must match the head of the tx queue.
    always @(negedge clk) begin
        if (rst && tx_valid && tx_ready) begin
            if (tx_exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_tx: data %0h, expected no byte", tx_data);
            end else begin
                check("tx_data", 32'(tx_data), 32'(tx_exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst && frame_done) done_cnt++;
    end

    // Offer n bytes (value = index) with rx_valid held high; start pulses at byte sp.
    task automatic load_frame(input int n, input int sp);
        for (int i = 0; i < n; i++) begin
            int w;
            wr_t e;
            rx_data  = 8'(i);
            rx_valid = 1'b1;
            w = 0;
            while (!rx_ready && w < 20) begin
                step(1);
                w++;
            end
            if (!rx_ready) begin
                check("rx_ready_timeout", 32'(rx_ready), 32'd1);
                return;
            end
            e.addr = 12'(i);
            e.data = 8'(i);
            e.gap  = (i == 0) ? 0 : 1;
            wr_q.push_back(e);
            start = (i == sp);
            step(1);
            start = 1'b0;
        end
    endtask

    task automatic push_proc(input int n);
        for (int i = 0; i < n; i++) begin
            wr_t e;
            e.addr = 12'(i);
            e.data = 8'(i) ^ 8'hFF;
            e.gap  = 5;
            wr_q.push_back(e);
        end
    endtask

    initial begin
        int w;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        step(2);

        // Reset state
        check("rst_busy",      32'(busy),       32'd0);
        check("rst_rx_ready",  32'(rx_ready),   32'd0);
        check("rst_ctl",       32'({tx_valid, pau_req, ram_wr_en, frame_done}), 32'd0);
        check("rst_data",      32'({ram_addr, ram_wdata, tx_data, pau_color}),  32'd0);

        rst = 1'b1;
        step(3);
        check("idle_no_start", 32'(busy), 32'd0);
        start = 1'b1; abort = 1'b1;
        step(1);
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'd0);
        step(2);

        // Reset during LOAD at addr 17
        start = 1'b1;
        step(1);
        start = 1'b0;
        load_frame(17, -1);
        rx_data = 8'd17;
        check("load_addr17", 32'(ram_addr), 32'd17);
        rst = 1'b0;
        #1;
        check("midrst_busy",  32'(busy),      32'd0);
        check("midrst_addr",  32'(ram_addr),  32'd0);
        check("midrst_wr_en", 32'(ram_wr_en), 32'd0);
        step(2);
        rst = 1'b1;
        rx_valid = 1'b0;
        step(3);
        check("post_rst_idle", 32'(busy), 32'd0);
        check("post_rst_wrq",  32'(wr_q.size()), 32'd0);

        // Full frame with a stray start during LOAD and rx_valid held in PROC
        start = 1'b1;
        step(1);
        start = 1'b0;
        load_frame(4096, 1000);
        check("rd_rx_ready", 32'(rx_ready), 32'd0);
        push_proc(4096);
        for (int i = 0; i < 4096; i++) tx_exp_q.push_back(8'(i) ^ 8'hFF);
        w = 0;
        while (!pau_req && w < 10) begin step(1); w++; end
        check("proc_pau_req",  32'(pau_req),  32'd1);
        check("proc_rx_ready", 32'(rx_ready), 32'd0);
        w = 0;
        while (!tx_valid && w < 30000) begin step(1); w++; end
        check("tx_valid_seen", 32'(tx_valid), 32'd1);
        check("mem5_processed", 32'(mem[5]), 32'hFA);
        for (int k = 0; k < 3; k++) begin
            check("stall_tx_data",  32'(tx_data),  32'hFF);
            check("stall_tx_valid", 32'(tx_valid), 32'd1);
            step(1);
        end
        check("stall_tx_data_end", 32'(tx_data), 32'hFF);
        tx_ready = 1'b1;
        w = 0;
        while (busy && w < 20000) begin step(1); w++; end
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        step(2);
        check("frame_idle",      32'(busy),             32'd0);
        check("frame_done_cnt",  32'(done_cnt),         32'd1);
        check("frame_wrq_empty", 32'(wr_q.size()),      32'd0);
        check("frame_txq_empty", 32'(tx_exp_q.size()),  32'd0);

        // Abort in PROC at addr 100
        start = 1'b1;
        step(1);
        start = 1'b0;
        load_frame(4096, -1);
        rx_valid = 1'b0;
        push_proc(100);
        w = 0;
        while (!(pau_req && ram_addr == 12'd100) && w < 1000) begin step(1); w++; end
        check("abort_at_100", 32'(ram_addr), 32'd100);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("abort_busy",    32'(busy),     32'd0);
        check("abort_pau_req", 32'(pau_req),  32'd0);
        check("abort_addr",    32'(ram_addr), 32'd0);
        check("abort_ctl",     32'({tx_valid, rx_ready, ram_wr_en}), 32'd0);
        step(10);
        check("abort_wrq_empty", 32'(wr_q.size()), 32'd0);
        check("abort_mem100",    32'(mem[100]),    32'h64);
        check("abort_done_cnt",  32'(done_cnt),    32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
